alu_operand_sequencer: RTL and testbench
========================================

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, stable-level cycles required before a button change is accepted (minimum 2).
REQ-002 Parameter SETTLE_CYCLES, default 2, cycles between driving opcode and capturing ALU result (minimum 1).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_n  input  1  step push-button, active-low, asynchronous/bouncing.
REQ-006 sw_n  input  4  data switches, active-low, asynchronous.
REQ-007 alu_y_n  input  4  ALU result, active-low.
REQ-008 alu_cout_n  input  1  ALU carry/borrow, active-low.
REQ-009 alu_nz  input  1  ALU flag, high when result nonzero.
REQ-010 ain_n  output  4  operand A to ALU, active-low.
REQ-011 bin_n  output  4  operand B to ALU, active-low.
REQ-012 opcode_n  output  3  opcode to ALU, active-low.
REQ-013 led_n  output  4  display, active-low.
REQ-014 carry_led_n  output  1  captured carry, active-low.
REQ-015 zero_led_n  output  1  captured zero indication, active-low.
REQ-016 stage  output  3  one-hot phase: 001 enter A, 010 enter B, 100 enter opcode, 000 exec/show.
REQ-017 done  output  1  one-cycle pulse when result captured.

Function
REQ-018 btn_n and sw_n SHALL each pass through a two-flop synchronizer before any use.
REQ-019 Debouncer SHALL hold a stable level; counter increments while synced btn differs from stable, clears when equal; on reaching DEBOUNCE_CYCLES-1 stable takes synced value and counter clears.
REQ-020 press SHALL be a one-cycle internal pulse on stable 1->0 transition only; release generates nothing.
REQ-021 FSM states: ENTER_A, ENTER_B, ENTER_OP, EXEC, SHOW.
REQ-022 ENTER_A + press: a_reg <= ~sw_sync, go ENTER_B.
REQ-023 ENTER_B + press: b_reg <= ~sw_sync, go ENTER_OP.
REQ-024 ENTER_OP + press: op_reg <= ~sw_sync[2:0], settle counter cleared, go EXEC.
REQ-025 EXEC: ignore presses; count SETTLE_CYCLES clocks, then capture res_reg <= ~alu_y_n, c_reg <= ~alu_cout_n, z_reg <= ~alu_nz, pulse done, go SHOW.
REQ-026 SHOW + press: go ENTER_A; a_reg, b_reg, op_reg, res_reg, flags retained until overwritten.
REQ-027 ain_n = ~a_reg, bin_n = ~b_reg, opcode_n = ~op_reg, continuously (registered values, no glitch between presses).
REQ-028 led_n = ~res_reg in SHOW; = ~(live ~sw_sync) i.e. follows switches in ENTER_*; = 4'hF in EXEC.
REQ-029 carry_led_n = ~c_reg, zero_led_n = ~z_reg in all states.
REQ-030 A press arriving same cycle as EXEC completion SHALL be discarded.
REQ-031 Held button SHALL produce exactly one press regardless of hold time.

Reset
REQ-032 rst SHALL force ENTER_A; a_reg, b_reg, res_reg = 0, op_reg = 000, c_reg = z_reg = 0, done = 0.
REQ-033 After reset: ain_n = bin_n = 4'hF, opcode_n = 3'b111, carry_led_n = zero_led_n = 1, stage = 001.
REQ-034 Synchronizers SHALL reset to 1 (released), debounce stable = 1, counters = 0.
REQ-035 rst asserted in any state, including mid-EXEC or mid-debounce, SHALL abandon operation with no done pulse.

Verification (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2)
REQ-036 Reset -> ain_n=F, bin_n=F, opcode_n=111, stage=001, done=0.
REQ-037 sw_n=~3, press; sw_n=~5, press; sw_n=~000, press; ALU model returns 8 -> ain_n=~3, bin_n=~5, opcode_n=111, done one cycle, led_n=~8, carry_led_n=1.
REQ-038 btn_n toggles every cycle for 10 cycles then high -> no press, stage unchanged.
REQ-039 btn_n held low 50 cycles -> exactly one stage advance.
REQ-040 Press during EXEC -> ignored, SHOW reached after SETTLE_CYCLES; press in SHOW -> stage=001, ain_n still ~3.
REQ-041 rst pulse during EXEC -> no done, stage=001, all outputs at reset values.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Front-panel sequencer for a 4-bit ALU: debounced step button walks through operand A, operand B,
// opcode entry, then waits for the ALU to settle, captures its result and flags, and shows them.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic [3:0] sw_n,
    input  logic [3:0] alu_y_n,
    input  logic       alu_cout_n,
    input  logic       alu_nz,
    output logic [3:0] ain_n,
    output logic [3:0] bin_n,
    output logic [2:0] opcode_n,
    output logic [3:0] led_n,
    output logic       carry_led_n,
    output logic       zero_led_n,
    output logic [2:0] stage,
    output logic       done
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_ENTER_OP = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SHOW     = 3'd4
    } state_t;

    function automatic logic [2:0] stage_of(input state_t s);
        logic [2:0] v;
        case (s)
            ST_ENTER_A:  v = 3'b001;
            ST_ENTER_B:  v = 3'b010;
            ST_ENTER_OP: v = 3'b100;
            default:     v = 3'b000;
        endcase
        return v;
    endfunction

    logic            btn_meta_r, btn_sync_r;
    logic [3:0]      sw_meta_r, sw_sync_r;
    logic            stable_r, stable_nxt_s;
    logic [DB_W-1:0] db_cnt_r, db_cnt_nxt_s;
    logic            press_r, press_nxt_s;
    state_t          state_r, state_nxt_s;
    logic [ST_W-1:0] settle_r, settle_nxt_s;
    logic [3:0]      a_r, a_nxt_s, b_r, b_nxt_s, res_r, res_nxt_s;
    logic [2:0]      op_r, op_nxt_s;
    logic            c_r, c_nxt_s, z_r, z_nxt_s;
    logic            done_r, done_nxt_s;
    logic [2:0]      stage_r, stage_nxt_s;
    logic [3:0]      led_n_r, led_n_nxt_s;
    logic [3:0]      sw_val_s;

    assign sw_val_s = ~sw_sync_r;

    // Two-flop synchronizers; idle level of the active-low inputs is all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
            sw_meta_r  <= 4'hF;
            sw_sync_r  <= 4'hF;
        end else begin
            btn_meta_r <= btn_n;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= sw_n;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Debouncer: the level must disagree with the stable value for DEBOUNCE_CYCLES clocks in a row.
    always_comb begin
        stable_nxt_s = stable_r;
        db_cnt_nxt_s = DB_W'(0);
        if (btn_sync_r != stable_r) begin
            if (db_cnt_r == DB_LAST) begin
                stable_nxt_s = btn_sync_r;
                db_cnt_nxt_s = DB_W'(0);
            end else begin
                stable_nxt_s = stable_r;
                db_cnt_nxt_s = db_cnt_r + DB_W'(1);
            end
        end else begin
            stable_nxt_s = stable_r;
            db_cnt_nxt_s = DB_W'(0);
        end
        press_nxt_s = stable_r & ~stable_nxt_s;
    end

    // Phase sequencing, operand capture and settle timing.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        a_nxt_s      = a_r;
        b_nxt_s      = b_r;
        op_nxt_s     = op_r;
        res_nxt_s    = res_r;
        c_nxt_s      = c_r;
        z_nxt_s      = z_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_ENTER_A: begin
                if (press_r) begin
                    a_nxt_s     = sw_val_s;
                    state_nxt_s = ST_ENTER_B;
                end else begin
                    state_nxt_s = ST_ENTER_A;
                end
            end
            ST_ENTER_B: begin
                if (press_r) begin
                    b_nxt_s     = sw_val_s;
                    state_nxt_s = ST_ENTER_OP;
                end else begin
                    state_nxt_s = ST_ENTER_B;
                end
            end
            ST_ENTER_OP: begin
                if (press_r) begin
                    op_nxt_s     = sw_val_s[2:0];
                    settle_nxt_s = ST_W'(0);
                    state_nxt_s  = ST_EXEC;
                end else begin
                    state_nxt_s = ST_ENTER_OP;
                end
            end
            ST_EXEC: begin
                // Presses are dropped here, including one landing on the capture cycle.
                if (settle_r == ST_LAST) begin
                    res_nxt_s   = ~alu_y_n;
                    c_nxt_s     = ~alu_cout_n;
                    z_nxt_s     = ~alu_nz;
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_SHOW;
                end else begin
                    settle_nxt_s = settle_r + ST_W'(1);
                    state_nxt_s  = ST_EXEC;
                end
            end
            ST_SHOW: begin
                if (press_r) begin
                    state_nxt_s = ST_ENTER_A;
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            default: state_nxt_s = ST_ENTER_A;
        endcase
    end

    // Display and stage values are derived from the upcoming state so they register alongside it.
    always_comb begin
        stage_nxt_s = stage_of(state_nxt_s);
        case (state_nxt_s)
            ST_SHOW: led_n_nxt_s = ~res_nxt_s;
            ST_EXEC: led_n_nxt_s = 4'hF;
            default: led_n_nxt_s = sw_sync_r;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= 1'b1;
            db_cnt_r <= DB_W'(0);
            press_r  <= 1'b0;
            state_r  <= ST_ENTER_A;
            settle_r <= ST_W'(0);
            a_r      <= 4'h0;
            b_r      <= 4'h0;
            op_r     <= 3'b000;
            res_r    <= 4'h0;
            c_r      <= 1'b0;
            z_r      <= 1'b0;
            done_r   <= 1'b0;
            stage_r  <= 3'b001;
            led_n_r  <= 4'hF;
        end else begin
            stable_r <= stable_nxt_s;
            db_cnt_r <= db_cnt_nxt_s;
            press_r  <= press_nxt_s;
            state_r  <= state_nxt_s;
            settle_r <= settle_nxt_s;
            a_r      <= a_nxt_s;
            b_r      <= b_nxt_s;
            op_r     <= op_nxt_s;
            res_r    <= res_nxt_s;
            c_r      <= c_nxt_s;
            z_r      <= z_nxt_s;
            done_r   <= done_nxt_s;
            stage_r  <= stage_nxt_s;
            led_n_r  <= led_n_nxt_s;
        end
    end

    assign ain_n       = ~a_r;
    assign bin_n       = ~b_r;
    assign opcode_n    = ~op_r;
    assign carry_led_n = ~c_r;
    assign zero_led_n  = ~z_r;
    assign led_n       = led_n_r;
    assign stage       = stage_r;
    assign done        = done_r;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed and random operand entry against a phase-level model
// with a behavioural ALU attached to the operand/opcode outputs.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst, btn_n, alu_cout_n, alu_nz;
    logic [3:0] sw_n, alu_y_n, ain_n, bin_n, led_n;
    logic [2:0] opcode_n, stage;
    logic       carry_led_n, zero_led_n, done;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int done_cnt = 0;

    // Model of the user-visible machine.
    int         phase;      // 0 enter A, 1 enter B, 2 enter opcode, 3 show
    logic [3:0] exp_a, exp_b, exp_res;
    logic [2:0] exp_op;
    logic       exp_c, exp_z;
    int         exp_done;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .sw_n(sw_n), .alu_y_n(alu_y_n),
        .alu_cout_n(alu_cout_n), .alu_nz(alu_nz), .ain_n(ain_n), .bin_n(bin_n),
        .opcode_n(opcode_n), .led_n(led_n), .carry_led_n(carry_led_n),
        .zero_led_n(zero_led_n), .stage(stage), .done(done)
    );

    // Behavioural ALU: {carry, result}.
    function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, ~a};
            3'd6:    r = {a[3], a[2:0], 1'b0};
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    logic [4:0] alu_r;
    assign alu_r      = alu_f(~opcode_n, ~ain_n, ~bin_n);
    assign alu_y_n    = ~alu_r[3:0];
    assign alu_cout_n = ~alu_r[4];
    assign alu_nz     = |alu_r[3:0];

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_stage();
        case (phase)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_stage"}, {5'd0, stage}, {5'd0, exp_stage()});
        check({tag, "_ain"}, {4'd0, ain_n}, {4'd0, ~exp_a});
        check({tag, "_bin"}, {4'd0, bin_n}, {4'd0, ~exp_b});
        check({tag, "_op"}, {5'd0, opcode_n}, {5'd0, ~exp_op});
        check({tag, "_led"}, {4'd0, led_n}, {4'd0, (phase == 3) ? ~exp_res : sw_n});
        check({tag, "_cled"}, {7'd0, carry_led_n}, {7'd0, ~exp_c});
        check({tag, "_zled"}, {7'd0, zero_led_n}, {7'd0, ~exp_z});
        check({tag, "_done"}, 8'(done_cnt), 8'(exp_done));
    endtask

    task automatic model_reset();
        phase = 0; exp_a = 4'h0; exp_b = 4'h0; exp_op = 3'b000;
        exp_res = 4'h0; exp_c = 1'b0; exp_z = 1'b0;
    endtask

    task automatic model_press();
        logic [4:0] r;
        case (phase)
            0: begin exp_a = ~sw_n; phase = 1; end
            1: begin exp_b = ~sw_n; phase = 2; end
            2: begin
                exp_op = ~sw_n[2:0];
                r = alu_f(exp_op, exp_a, exp_b);
                exp_res = r[3:0]; exp_c = r[4]; exp_z = (r[3:0] == 4'h0);
                exp_done++; phase = 3;
            end
            default: phase = 0;
        endcase
    endtask

    task automatic set_sw(input logic [3:0] v);
        sw_n = v;
        tick(4);
    endtask

    task automatic press();
        btn_n = 1'b0; tick(10);
        btn_n = 1'b1; tick(10);
        model_press();
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic [2:0] rop;
        bit seen;
        rst = 1'b1; btn_n = 1'b1; sw_n = 4'hF; exp_done = 0;
        model_reset();
        tick(3);
        check("reset_done_level", {7'd0, done}, 8'd0);
        rst = 1'b0;
        tick(5);
        check_all("reset");

        // 3 + 5 with opcode 000 gives 8, no carry.
        set_sw(~4'd3); press();
        set_sw(~4'd5); press();
        set_sw(~4'd0); press();
        check_all("add35");
        check("add35_led8", {4'd0, led_n}, {4'd0, ~4'd8});

        // Bounce for 10 cycles must not produce a press.
        for (int i = 0; i < 10; i++) begin btn_n = ~btn_n; tick(1); end
        btn_n = 1'b1; tick(20);
        check_all("bounce");

        // Press in SHOW returns to operand A entry; A keeps the old value.
        press();
        check_all("show_to_a");

        // Long hold gives exactly one advance.
        set_sw(~4'd9);
        btn_n = 1'b0; tick(50);
        btn_n = 1'b1; tick(10);
        model_press();
        check_all("held50");

        // Chatter while the ALU is settling is ignored.
        set_sw(~4'd12); press();
        set_sw(~4'd1);
        btn_n = 1'b0; tick(7);
        for (int i = 0; i < 6; i++) begin btn_n = ~btn_n; tick(1); end
        btn_n = 1'b1; tick(20);
        model_press();
        check_all("exec_chatter");

        // Reset while executing: no done, everything back to reset values.
        press();
        set_sw(~4'd7); press();
        set_sw(~4'd6); press();
        set_sw(~4'd0);
        btn_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (stage === 3'b000) seen = 1'b1;
        end
        check("exec_reached", {7'd0, seen}, 8'd1);
        rst = 1'b1; btn_n = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tick(10);
        check_all("rst_in_exec");

        // Random operations.
        for (int i = 0; i < 8; i++) begin
            ra = 4'($urandom_range(15)); rb = 4'($urandom_range(15)); rop = 3'($urandom_range(7));
            set_sw(~ra); press(); check_all("rnd_a");
            set_sw(~rb); press(); check_all("rnd_b");
            set_sw({1'($urandom_range(1)), ~rop}); press(); check_all("rnd_exec");
            press(); check_all("rnd_back");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
